// File: rtl/program_loader.sv
// Boot-time instruction loader: streams 32-bit words into instruction memory from
// address 0, holds the core in reset while loading and releases it after a fixed delay.
module program_loader #(
    parameter int ADDR_W         = 10,
    parameter int MAX_WORDS      = 1024,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic [31:0]        checksum_q, checksum_d;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               accept;

    assign in_ready = (state_q == S_LOAD) && (word_count_q < MAX_CNT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        rel_cnt_d    = rel_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
                    checksum_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_W-1:0];
                    imem_wdata_d = in_data;
                    word_count_d = word_count_q + CNT_W'(1);
                    checksum_d   = checksum_q + in_data;
                    if (in_last) begin
                        state_d = S_DRAIN;
                    end
                end else if (in_valid && (word_count_q == MAX_CNT)) begin
                    state_d = S_ERROR;
                end
            end
            S_DRAIN: begin
                state_d   = S_RELEASE;
                rel_cnt_d = '0;
            end
            S_RELEASE: begin
                if (rel_cnt_q == REL_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            S_RUN, S_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A restart overrides any progress; the DRAIN write is already on the bus this cycle.
        if (start && (state_q != S_LOAD) && (state_q != S_IDLE)) begin
            state_d      = S_LOAD;
            word_count_d = '0;
            checksum_d   = '0;
        end

        cpu_rst_d = (state_d != S_RUN);
        busy_d    = (state_d == S_LOAD) || (state_d == S_DRAIN) || (state_d == S_RELEASE);
        done_d    = (state_d == S_RUN);
        error_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            checksum_q   <= '0;
            rel_cnt_q    <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            rel_cnt_q    <= rel_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a timestamp-based behavioural model compared every
// cycle, plus directed literal checks for the documented load, release, overflow and reset cases.
module tb_program_loader;

    localparam int ADDR_W         = 3;
    localparam int MAX_WORDS      = 4;
    localparam int RELEASE_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    int total = 0;
    int bad   = 0;
    bit checking_on = 1'b0;

    program_loader #(
        .ADDR_W(ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .done(done),
        .error(error),
        .word_count(word_count),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Model: phase plus "edges since the final accept" decides drain/release/run timing.
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_FIN  = 2;
    localparam int P_ERR  = 3;

    int          m_phase = P_IDLE;
    int          m_count = 0;
    logic [31:0] m_sum   = '0;
    bit          m_we    = 1'b0;
    int          m_addr  = 0;
    logic [31:0] m_wdata = '0;
    int          m_k     = 0;
    bit          m_ready_before;
    bit          m_was_loading;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_phase = P_IDLE;
                m_count = 0;
                m_sum   = '0;
                m_we    = 1'b0;
                m_addr  = 0;
                m_wdata = '0;
                m_k     = 0;
            end else begin
                m_was_loading  = (m_phase == P_LOAD);
                m_ready_before = m_was_loading && (m_count < MAX_WORDS);
                m_we = 1'b0;
                if (m_phase == P_FIN) m_k = m_k + 1;
                if (m_was_loading) begin
                    if (in_valid && m_ready_before) begin
                        m_we    = 1'b1;
                        m_addr  = m_count;
                        m_wdata = in_data;
                        m_count = m_count + 1;
                        m_sum   = m_sum + in_data;
                        if (in_last) begin
                            m_phase = P_FIN;
                            m_k     = 0;
                        end
                    end else if (in_valid) begin
                        m_phase = P_ERR;
                    end
                end else if (start) begin
                    m_phase = P_LOAD;
                    m_count = 0;
                    m_sum   = '0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle compare all outputs against what the model says they must be.
    initial begin
        bit exp_run;
        bit exp_busy;
        forever begin
            @(negedge clk);
            if (checking_on) begin
                exp_run  = (m_phase == P_FIN) && (m_k >= RELEASE_CYCLES + 1);
                exp_busy = (m_phase == P_LOAD) || ((m_phase == P_FIN) && (m_k <= RELEASE_CYCLES));
                checkOutput("in_ready", 32'(in_ready), 32'((m_phase == P_LOAD) && (m_count < MAX_WORDS)));
                checkOutput("imem_we", 32'(imem_we), 32'(m_we));
                checkOutput("imem_addr", 32'(imem_addr), 32'(m_addr));
                checkOutput("imem_wdata", imem_wdata, m_wdata);
                checkOutput("cpu_rst", 32'(cpu_rst), 32'(!exp_run));
                checkOutput("busy", 32'(busy), 32'(exp_busy));
                checkOutput("done", 32'(done), 32'(exp_run));
                checkOutput("error", 32'(error), 32'(m_phase == P_ERR));
                checkOutput("word_count", 32'(word_count), 32'(m_count));
                checkOutput("checksum", checksum, m_sum);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit s, input bit v, input logic [31:0] d, input bit l);
        start    = s;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Hold a beat until the loader takes it; returns right after the accepting edge.
    task automatic sendBeat(input logic [31:0] d, input bit l, input bit s);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        start    = s;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            bad = bad + 1;
            total = total + 1;
            $display("[TB] FAIL beat_wait: in_ready never rose, got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_we"}, 32'(imem_we), 32'd0);
        checkOutput({tag, "_addr"}, 32'(imem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, imem_wdata, 32'd0);
        checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_wc"}, 32'(word_count), 32'd0);
        checkOutput({tag, "_ck"}, checksum, 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] prog [3];
        int n;
        prog[0] = 32'h00500093;
        prog[1] = 32'h00300113;
        prog[2] = 32'h002081B3;

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        tick(); tick();
        checkResetValues("reset");
        checking_on = 1'b1;
        rst = 1'b1;
        tick();

        // Three-word program, then the release delay measured from the final accept.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sendBeat(prog[i], i == 2, 1'b0);
            checkOutput("t1_we", 32'(imem_we), 32'd1);
            checkOutput("t1_addr", 32'(imem_addr), 32'(i));
            checkOutput("t1_wdata", imem_wdata, prog[i]);
        end
        checkOutput("t1_wc", 32'(word_count), 32'd3);
        checkOutput("t1_ck", checksum, 32'h00A08359);
        for (int i = 1; i <= RELEASE_CYCLES; i++) begin
            tick();
            checkOutput("t2_cpu_rst_held", 32'(cpu_rst), 32'd1);
        end
        tick();
        checkOutput("t2_cpu_rst_fall", 32'(cpu_rst), 32'd0);
        checkOutput("t2_done", 32'(done), 32'd1);
        tick();

        // Reload from RUN with a gap between the two beats.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("t5_wc", 32'(word_count), 32'd0);
        sendBeat(32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("t5_addr0", 32'(imem_addr), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h12345678, 1'b0);
        checkOutput("t3_gap_we", 32'(imem_we), 32'd0);
        sendBeat(32'h00000013, 1'b1, 1'b0);
        checkOutput("t5_addr1", 32'(imem_addr), 32'd1);
        checkOutput("t5_ck", checksum, 32'hDEADBF02);
        for (int i = 0; i < RELEASE_CYCLES + 1; i++) tick();
        checkOutput("t5_done", 32'(done), 32'd1);

        // Overflow: four words fill memory, the fifth valid beat errors out.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < MAX_WORDS; i++) sendBeat(32'h100 + 32'(i), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hBADBAD00;
        #1;
        checkOutput("t4_ready_full", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("t4_error", 32'(error), 32'd1);
        checkOutput("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("t4_wc", 32'(word_count), 32'd4);
        tick(); tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_restart_wc", 32'(word_count), 32'd0);
        checkOutput("t4_restart_busy", 32'(busy), 32'd1);

        // Asynchronous reset in the middle of a load.
        sendBeat(32'hA, 1'b0, 1'b0);
        sendBeat(32'hB, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1 checkResetValues("t6");
        tick();
        rst = 1'b1;
        tick();

        // Randomized loads with random gaps, restarts from every phase, and overflow attempts.
        for (int iter = 0; iter < 40; iter++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
            n = $urandom_range(1, MAX_WORDS + 1);
            for (int i = 0; i < n && i < MAX_WORDS; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) applyStimulus(1'b0, 1'b0, $urandom, 1'b1);
                sendBeat($urandom, (i == n - 1), ($urandom_range(0, 7) == 0));
            end
            if (n > MAX_WORDS) applyStimulus(1'b0, 1'b1, $urandom, 1'b0);
            for (int w = $urandom_range(0, 10); w > 0; w--)
                applyStimulus(1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
        end
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
